// File: rtl/collision_scheduler.sv
// Walks the object table once per start, running the shared overlap comparator on each slot against the latched player.
// Optional feature: define COLLISION_EARLY_EXIT_EN to end the scan at the first hit.
module collision_scheduler #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = $clog2(N_OBJ)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [18:0]      i_PlayerPos,
  input  logic [5:0]       i_PlayerWidth,
  input  logic [5:0]       i_PlayerHeight,
  output logic [IDX_W-1:0] o_ObjAddr,
  input  logic [18:0]      i_ObjPos,
  input  logic [5:0]       i_ObjWidth,
  input  logic [5:0]       i_ObjHeight,
  input  logic             i_ObjValid,
  output logic [18:0]      o_ObjAPos,
  output logic [5:0]       o_ObjAWidth,
  output logic [5:0]       o_ObjAHeight,
  output logic [18:0]      o_ObjBPos,
  output logic [5:0]       o_ObjBWidth,
  output logic [5:0]       o_ObjBHeight,
  input  logic             i_IsCollision,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [N_OBJ-1:0] o_HitMask,
  output logic             o_AnyHit,
  output logic [IDX_W-1:0] o_HitIdx
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_TEST, S_DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_OBJ-1:0]   hit_mask_q, hit_mask_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [18:0]        player_pos_q, player_pos_d;
  logic [5:0]         player_w_q, player_w_d;
  logic [5:0]         player_h_q, player_h_d;
  logic               hit;

  assign hit = i_ObjValid & i_IsCollision;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hit_mask_q   <= '0;
      hit_idx_q    <= '0;
      player_pos_q <= '0;
      player_w_q   <= '0;
      player_h_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_mask_q   <= hit_mask_d;
      hit_idx_q    <= hit_idx_d;
      player_pos_q <= player_pos_d;
      player_w_q   <= player_w_d;
      player_h_q   <= player_h_d;
    end
  end

  // NOTE: every signal gets a hold default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_mask_d   = hit_mask_q;
    hit_idx_d    = hit_idx_q;
    player_pos_d = player_pos_q;
    player_w_d   = player_w_q;
    player_h_d   = player_h_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          player_pos_d = i_PlayerPos;
          player_w_d   = i_PlayerWidth;
          player_h_d   = i_PlayerHeight;
          idx_d        = '0;
          hit_mask_d   = '0;
          hit_idx_d    = '0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: state_d = S_TEST;
      S_TEST: begin
        if (hit) begin
          hit_mask_d[idx_q] = 1'b1;
          // An empty mask means no earlier slot of this scan has hit.
          if (hit_mask_q == '0) hit_idx_d = idx_q;
        end
`ifdef COLLISION_EARLY_EXIT_EN
        if (hit || idx_q == LAST_IDX) begin
`else
        if (idx_q == LAST_IDX) begin
`endif
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_Busy = (state_q != S_IDLE);
    o_Done = (state_q == S_DONE);
  end

  assign o_ObjAddr    = idx_q;
  assign o_ObjAPos    = player_pos_q;
  assign o_ObjAWidth  = player_w_q;
  assign o_ObjAHeight = player_h_q;
  assign o_ObjBPos    = i_ObjPos;
  assign o_ObjBWidth  = i_ObjWidth;
  assign o_ObjBHeight = i_ObjHeight;
  assign o_HitMask    = hit_mask_q;
  assign o_AnyHit     = |hit_mask_q;
  assign o_HitIdx     = hit_idx_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a strict-overlap comparator and a 1-cycle-latency object table.
module tb_collision_scheduler;

  localparam int N_OBJ = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             i_Rst = 1'b1;
  logic             i_Start = 1'b0;
  logic [18:0]      i_PlayerPos = {10'd100, 9'd100};
  logic [5:0]       i_PlayerWidth = 6'd16;
  logic [5:0]       i_PlayerHeight = 6'd16;
  logic [IDX_W-1:0] o_ObjAddr;
  logic [18:0]      i_ObjPos = '0;
  logic [5:0]       i_ObjWidth = '0;
  logic [5:0]       i_ObjHeight = '0;
  logic             i_ObjValid = 1'b0;
  logic [18:0]      o_ObjAPos, o_ObjBPos;
  logic [5:0]       o_ObjAWidth, o_ObjAHeight, o_ObjBWidth, o_ObjBHeight;
  logic             i_IsCollision;
  logic             o_Busy, o_Done, o_AnyHit;
  logic [N_OBJ-1:0] o_HitMask;
  logic [IDX_W-1:0] o_HitIdx;

  collision_scheduler #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Start(i_Start),
    .i_PlayerPos(i_PlayerPos), .i_PlayerWidth(i_PlayerWidth), .i_PlayerHeight(i_PlayerHeight),
    .o_ObjAddr(o_ObjAddr), .i_ObjPos(i_ObjPos), .i_ObjWidth(i_ObjWidth),
    .i_ObjHeight(i_ObjHeight), .i_ObjValid(i_ObjValid),
    .o_ObjAPos(o_ObjAPos), .o_ObjAWidth(o_ObjAWidth), .o_ObjAHeight(o_ObjAHeight),
    .o_ObjBPos(o_ObjBPos), .o_ObjBWidth(o_ObjBWidth), .o_ObjBHeight(o_ObjBHeight),
    .i_IsCollision(i_IsCollision), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_HitMask(o_HitMask), .o_AnyHit(o_AnyHit), .o_HitIdx(o_HitIdx)
  );

  always #5 clk = ~clk;

  // Object table: registered read, data appears the cycle after the address.
  int tx[N_OBJ], ty[N_OBJ], tw[N_OBJ], th[N_OBJ];
  bit tv[N_OBJ];

  always @(posedge clk) begin
    i_ObjPos    <= {10'(tx[o_ObjAddr]), 9'(ty[o_ObjAddr])};
    i_ObjWidth  <= 6'(tw[o_ObjAddr]);
    i_ObjHeight <= 6'(th[o_ObjAddr]);
    i_ObjValid  <= tv[o_ObjAddr];
  end

  // Strict overlap: edge contact is not a collision.
  int ax, ay, aw, ah, bx, by, bw, bh;
  always_comb begin
    ax = int'(o_ObjAPos[18:9]); ay = int'(o_ObjAPos[8:0]);
    aw = int'(o_ObjAWidth);     ah = int'(o_ObjAHeight);
    bx = int'(o_ObjBPos[18:9]); by = int'(o_ObjBPos[8:0]);
    bw = int'(o_ObjBWidth);     bh = int'(o_ObjBHeight);
    i_IsCollision = (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  end

  typedef struct {
    int sa; int ax; int ay; int aw; int ah; bit av;
    int sb; int bx; int by; int bw; int bh; bit bv;
    logic [7:0] mask; int hidx; int done_cyc;
  } vec_t;

  vec_t vecs[5];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Empty slots carry an overlapping rectangle so only the valid flag keeps them out.
  task automatic clear_table();
    for (int i = 0; i < N_OBJ; i++) begin
      tx[i] = 104; ty[i] = 104; tw[i] = 8; th[i] = 8; tv[i] = 1'b0;
    end
  endtask

  task automatic put_slot(input int s, input int x, input int y, input int w, input int h, input bit v);
    tx[s] = x; ty[s] = y; tw[s] = w; th[s] = h; tv[s] = v;
  endtask

  task automatic start_scan();
    @(negedge clk); i_Start = 1'b1;
    @(posedge clk); #1; i_Start = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after the start edge) on which o_Done is seen, or -1.
  task automatic wait_done(output int done_c);
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      if (o_Done) begin done_c = c; break; end
      @(posedge clk); #1;
    end
  endtask

  int done_c;
  int done_seen;

  initial begin
    // Player (100,100) 16x16 spans x,y 100..115.
    vecs[0] = '{3, 110, 108, 8, 8, 1'b1, -1, 0, 0, 0, 0, 1'b0, 8'h08, 3, 17};
    vecs[1] = '{3, 116, 100, 8, 8, 1'b1, 5, 104, 104, 8, 8, 1'b0, 8'h00, 0, 17};
`ifdef COLLISION_EARLY_EXIT_EN
    vecs[0].done_cyc = 9;
    vecs[2] = '{2, 90, 90, 16, 16, 1'b1, 6, 112, 112, 8, 8, 1'b1, 8'h04, 2, 7};
    vecs[3] = '{0, 85, 100, 16, 16, 1'b1, 7, 100, 115, 4, 4, 1'b1, 8'h01, 0, 3};
    vecs[4] = '{4, 100, 84, 16, 16, 1'b1, 1, 100, 100, 16, 16, 1'b1, 8'h02, 1, 5};
`else
    vecs[2] = '{2, 90, 90, 16, 16, 1'b1, 6, 112, 112, 8, 8, 1'b1, 8'h44, 2, 17};
    vecs[3] = '{0, 85, 100, 16, 16, 1'b1, 7, 100, 115, 4, 4, 1'b1, 8'h81, 0, 17};
    vecs[4] = '{4, 100, 84, 16, 16, 1'b1, 1, 100, 100, 16, 16, 1'b1, 8'h02, 1, 17};
`endif
    clear_table();

    repeat (2) @(posedge clk);
    #1 i_Rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_Busy), 0);
    check("rst_done", 32'(o_Done), 0);
    check("rst_mask", 32'(o_HitMask), 0);
    check("rst_anyhit", 32'(o_AnyHit), 0);
    check("rst_hitidx", 32'(o_HitIdx), 0);
    check("rst_addr", 32'(o_ObjAddr), 0);
    check("rst_apos", 32'(o_ObjAPos), 0);

    for (int i = 0; i < 5; i++) begin
      clear_table();
      put_slot(vecs[i].sa, vecs[i].ax, vecs[i].ay, vecs[i].aw, vecs[i].ah, vecs[i].av);
      if (vecs[i].sb >= 0)
        put_slot(vecs[i].sb, vecs[i].bx, vecs[i].by, vecs[i].bw, vecs[i].bh, vecs[i].bv);
      start_scan();
      wait_done(done_c);
      check($sformatf("v%0d_done_cycle", i), 32'(done_c), 32'(vecs[i].done_cyc));
      check($sformatf("v%0d_mask", i), 32'(o_HitMask), 32'(vecs[i].mask));
      check($sformatf("v%0d_anyhit", i), 32'(o_AnyHit), 32'(vecs[i].mask != 0));
      check($sformatf("v%0d_hitidx", i), 32'(o_HitIdx), 32'(vecs[i].hidx));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(o_Done), 0);
      check($sformatf("v%0d_mask_hold", i), 32'(o_HitMask), 32'(vecs[i].mask));
    end

    // Re-pulsed start mid-scan and on DONE is ignored; player change mid-scan has no effect.
    clear_table();
    put_slot(2, 90, 90, 16, 16, 1'b1);
    put_slot(6, 112, 112, 8, 8, 1'b1);
    start_scan();
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      i_Start = (c == 5) || o_Done;
      if (c == 3) i_PlayerPos = {10'd500, 9'd400};
      if (o_Done) begin done_c = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_Start = 1'b0;
    i_PlayerPos = {10'd100, 9'd100};
    check("rp_done_cycle", 32'(done_c), 32'(vecs[2].done_cyc));
    check("rp_idle_after_done", 32'(o_Busy), 0);
    check("rp_mask_hold", 32'(o_HitMask), 32'(vecs[2].mask));
    clear_table();
    put_slot(3, 110, 108, 8, 8, 1'b1);
    start_scan();
    check("rp_restart_busy", 32'(o_Busy), 1);
    check("rp_restart_clear", 32'(o_HitMask), 0);
    wait_done(done_c);
    check("rp_rescan_done", 32'(done_c), 32'(vecs[0].done_cyc));
    check("rp_rescan_mask", 32'(o_HitMask), 32'h08);
    check("rp_rescan_idx", 32'(o_HitIdx), 3);
    @(posedge clk); #1;

    // Reset mid-scan at cycle 9 aborts with no DONE.
    clear_table();
`ifdef COLLISION_EARLY_EXIT_EN
    put_slot(6, 112, 112, 8, 8, 1'b1);
`else
    put_slot(2, 90, 90, 16, 16, 1'b1);
    put_slot(6, 112, 112, 8, 8, 1'b1);
`endif
    start_scan();
    for (int c = 1; c < 9; c++) begin
      @(posedge clk); #1;
    end
    check("mr_busy_c9", 32'(o_Busy), 1);
    check("mr_addr_c9", 32'(o_ObjAddr), 4);
`ifdef COLLISION_EARLY_EXIT_EN
    check("mr_mask_c9", 32'(o_HitMask), 32'h00);
`else
    check("mr_mask_c9", 32'(o_HitMask), 32'h04);
`endif
    i_Rst = 1'b1;
    @(posedge clk); #1;
    i_Rst = 1'b0;
    check("mr_busy", 32'(o_Busy), 0);
    check("mr_done", 32'(o_Done), 0);
    check("mr_mask", 32'(o_HitMask), 0);
    check("mr_addr", 32'(o_ObjAddr), 0);
    check("mr_apos", 32'(o_ObjAPos), 0);
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (o_Done || o_Busy) done_seen++;
    end
    check("mr_no_done", 32'(done_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequences one shared pairwise rectangle-overlap comparator across a table of game objects each frame. On a start pulse it latches the player rectangle and walks object slots 0..N_OBJ-1. For each slot it reads the slot from the object table and presents the pair to the comparator, then records the result in a hit bitmap. It sits between the frame timing logic, the object table RAM and the collision comparator, and feeds the game-state logic.

## Interface
- N_OBJ, default 8: number of object slots scanned; must be ≥2.
- IDX_W, default $clog2(N_OBJ): slot index width.
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Start  in  1  scan request pulse; accepted only in IDLE
- i_PlayerPos  in  19  player {x[9:0], y[8:0]}, sampled on accepted start
- i_PlayerWidth, i_PlayerHeight  in  6 each  player size, sampled on accepted start
- o_ObjAddr  out  IDX_W  object table read address (registered)
- i_ObjPos  in  19  slot position, valid one cycle after o_ObjAddr
- i_ObjWidth, i_ObjHeight  in  6 each  slot size, same timing as i_ObjPos
- i_ObjValid  in  1  slot occupied, same timing as i_ObjPos
- o_ObjAPos, o_ObjAWidth, o_ObjAHeight  out  19/6/6  comparator operand A = latched player
- o_ObjBPos, o_ObjBWidth, o_ObjBHeight  out  19/6/6  comparator operand B = i_Obj* passed through
- i_IsCollision  in  1  combinational comparator result for the current A/B
- o_Busy  out  1  high in FETCH, TEST, DONE
- o_Done  out  1  one-cycle pulse at scan end
- o_HitMask  out  N_OBJ  bit k set = slot k valid and colliding
- o_AnyHit  out  1  |o_HitMask
- o_HitIdx  out  IDX_W  lowest-index hit of the last scan; 0 if none

## Operation
- States: IDLE, FETCH, TEST, DONE.
- IDLE:
  - When i_Start=1: latch player fields, idx←0, o_HitMask←0, o_HitIdx←0, go to FETCH.
- FETCH:
  - o_ObjAddr=idx.
  - Next state is TEST.
- TEST:
  - Table data is valid this cycle.
  - Hit = i_ObjValid & i_IsCollision. On hit, set o_HitMask[idx].
  - o_HitIdx←idx if this is the first hit of the scan.
  - If idx==N_OBJ-1, go to DONE. Otherwise idx←idx+1 and go to FETCH.
- DONE:
  - o_Done=1.
  - Next state is IDLE.
- Empty slot (i_ObjValid=0) never hits, whatever i_IsCollision shows.
- i_Start in FETCH/TEST/DONE is ignored, not queued.
- i_Start on the same cycle as DONE is ignored; it is accepted from IDLE only.
- o_HitMask, o_AnyHit and o_HitIdx hold from DONE until the next accepted start.
- Comparator overlap is strict: rectangles that only touch at an edge do not collide. This block does no geometry itself.
- Player fields are stable for the whole scan, even if i_Player* changes mid-scan.
- idx never exceeds N_OBJ-1, so there is no wrap-around.

## Timing
- Reset values: state IDLE; o_ObjAddr 0; o_Busy 0; o_Done 0; o_HitMask 0; o_AnyHit 0; o_HitIdx 0; latched player 0.
- i_Rst mid-scan aborts immediately, with no o_Done.
- Start sampled at edge 0:
  - FETCH on cycles 1, 3, …, 2N_OBJ−1.
  - TEST on cycles 2, 4, …, 2N_OBJ.
  - DONE (o_Done=1) on cycle 2N_OBJ+1.
- Default N_OBJ=8: o_Done on cycle 17. The next start can be accepted at edge 18.
- o_HitMask bit for slot k updates at the end of cycle 2k+2.
- Final o_HitMask/o_HitIdx are valid on the o_Done cycle.

## Configuration
- COLLISION_EARLY_EXIT_EN defined:
  - A hit in TEST goes straight to DONE, on the cycle after that TEST.
  - o_HitMask then holds exactly one bit, and o_HitIdx is that slot.
  - Slot k hit gives o_Done on cycle 2k+3.
- Undefined: full scan always runs, and o_HitMask reports every colliding slot.

## Test plan
Bench uses a real strict-overlap comparator and a 1-cycle-latency table model. N_OBJ=8; player at (100,100), size 16×16.
- Reset, then idle 5 cycles → all outputs 0, o_ObjAddr 0.
- Slot 3 valid at (110,108), 8×8; others empty; start → o_Done cycle 17, o_HitMask=8'h08, o_AnyHit=1, o_HitIdx=3.
- Slot 3 at (116,100), touching only; slot 5 valid with i_ObjValid=0 at overlapping (104,104) → o_HitMask=0, o_HitIdx=0.
- Slots 2 and 6 overlapping:
  - Without the macro → mask 8'h44, HitIdx 2, Done cycle 17.
  - With COLLISION_EARLY_EXIT_EN → mask 8'h04, Done cycle 7.
- i_Start re-pulsed at cycle 5 and at the DONE cycle → ignored. The fresh start at cycle 18 clears the mask and rescans.
- i_Rst asserted at cycle 9 mid-scan → next cycle IDLE, mask 0, no o_Done.
